// File: rtl/scroll_sprite_bank.sv
// rtl/scroll_sprite_bank.sv - multi-channel leftward sprite scroller with LFSR Y reload on wrap
module scroll_sprite_bank #(
    parameter int         N_CH      = 3,
    parameter int         W         = 10,
    parameter int         X_MAX     = 639,
    parameter int         SPR_W     = 100,
    parameter int         Y_MIN     = 250,
    parameter int         Y_MASK    = 127,
    parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              run,
    input  logic [3:0]        speed,
    input  logic [3:0]        div,
    input  logic [N_CH*W-1:0] start_x,
    input  logic [N_CH*W-1:0] start_y,
    output logic [N_CH*W-1:0] pos_x,
    output logic [N_CH*W-1:0] pos_y,
    output logic [W-1:0]      size,
    output logic [N_CH-1:0]   wrap
);

    localparam int             WRAP_X   = X_MAX + SPR_W;
    localparam logic [W-1:0]   WRAP_XW  = W'(WRAP_X);
    localparam logic [9:0]     Y_MASK10 = 10'(Y_MASK);
    localparam logic [W:0]     Y_MINW   = (W+1)'(Y_MIN);

    generate
        if (WRAP_X > (1 << W) - 1) begin : g_wrap_x_check
            $error("scroll_sprite_bank: X_MAX + SPR_W does not fit in W bits");
        end
    endgenerate

    logic [3:0]   pre;
    logic [9:0]   lfsr;
    logic         step;
    logic [W-1:0] speed_w;

    assign step    = run && (pre >= div);
    assign speed_w = W'(speed);
    assign size    = W'(SPR_W);

    // The LFSR free-runs so reload Ys keep varying even while scrolling is paused.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            pre  <= 4'd0;
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            if (run) begin
                pre <= step ? 4'd0 : pre + 4'd1;
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            localparam int ROT = (3 * i) % 10;

            logic [W-1:0] px_q;
            logic [W-1:0] py_q;
            logic         wr_q;
            logic [9:0]   rot;
            logic [9:0]   drawn;
            logic [W:0]   y_sum;
            logic [W-1:0] y_new;

            // Each channel sees its own rotation so simultaneous wraps draw different Ys.
            assign rot   = (lfsr << ROT) | (lfsr >> (10 - ROT));
            assign drawn = rot & Y_MASK10;
            assign y_sum = Y_MINW + (W+1)'(drawn);
            assign y_new = y_sum[W] ? {W{1'b1}} : y_sum[W-1:0];

            always_ff @(posedge frame_clk or posedge Reset) begin
                if (Reset) begin
                    px_q <= start_x[i*W +: W];
                    py_q <= start_y[i*W +: W];
                    wr_q <= 1'b0;
                end else if (step) begin
                    if (px_q >= speed_w) begin
                        px_q <= px_q - speed_w;
                        wr_q <= 1'b0;
                    end else begin
                        px_q <= WRAP_XW;
                        py_q <= y_new;
                        wr_q <= 1'b1;
                    end
                end else begin
                    wr_q <= 1'b0;
                end
            end

            assign pos_x[i*W +: W] = px_q;
            assign pos_y[i*W +: W] = py_q;
            assign wrap[i]         = wr_q;
        end
    endgenerate

endmodule

// File: tb/tb_scroll_sprite_bank.sv
// tb/tb_scroll_sprite_bank.sv - directed self-checking bench for scroll_sprite_bank
module tb_scroll_sprite_bank;

    localparam int         N_CH = 3;
    localparam int         W    = 10;
    localparam logic [9:0] SEED = 10'h2A5;

    logic              frame_clk = 1'b0;
    logic              Reset     = 1'b1;
    logic              run       = 1'b0;
    logic [3:0]        speed     = 4'd0;
    logic [3:0]        div       = 4'd0;
    logic [N_CH*W-1:0] start_x;
    logic [N_CH*W-1:0] start_y;
    logic [N_CH*W-1:0] pos_x;
    logic [N_CH*W-1:0] pos_y;
    logic [W-1:0]      size;
    logic [N_CH-1:0]   wrap;

    int n_cmp = 0;
    int n_err = 0;
    int exp_y;

    logic [9:0] m_lfsr;
    logic [9:0] m_prev;

    scroll_sprite_bank dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .run       (run),
        .speed     (speed),
        .div       (div),
        .start_x   (start_x),
        .start_y   (start_y),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .size      (size),
        .wrap      (wrap)
    );

    always #5 frame_clk = ~frame_clk;

    // Reference LFSR: x^10 + x^7 + 1, m_prev holds the value in force before the last edge.
    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
        end
    end

    function automatic int gx(input int ch);
        return int'(pos_x[ch*W +: W]);
    endfunction

    function automatic int gy(input int ch);
        return int'(pos_y[ch*W +: W]);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        start_x = {10'd500, 10'd400, 10'd300};
        start_y = {10'd260, 10'd270, 10'd280};
        repeat (2) @(posedge frame_clk);
        #1;
        chk("rst_x0", gx(0), 300);
        chk("rst_x1", gx(1), 400);
        chk("rst_x2", gx(2), 500);
        chk("rst_y0", gy(0), 280);
        chk("rst_y1", gy(1), 270);
        chk("rst_y2", gy(2), 260);
        chk("rst_wrap", int'(wrap), 0);
        chk("size", int'(size), 100);

        Reset = 1'b0;
        run   = 1'b1;
        speed = 4'd1;
        div   = 4'd0;
        for (int e = 0; e < 5; e++) begin
            tick();
            chk("scroll_wrap", int'(wrap), 0);
        end
        chk("scroll_x0", gx(0), 295);
        chk("scroll_x1", gx(1), 395);
        chk("scroll_x2", gx(2), 495);
        chk("scroll_y0", gy(0), 280);

        run = 1'b0;
        pulse_reset();
        run   = 1'b1;
        speed = 4'd2;
        div   = 4'd3;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("div_x0", gx(0), (e >= 8) ? 296 : (e >= 4) ? 298 : 300);
        end
        repeat (2) tick();
        run = 1'b0;
        repeat (3) tick();
        chk("hold_x0", gx(0), 296);
        run = 1'b1;
        tick();
        chk("resume1_x0", gx(0), 296);
        tick();
        chk("resume2_x0", gx(0), 294);

        run     = 1'b0;
        start_x = {10'd500, 10'd400, 10'd2};
        pulse_reset();
        repeat (3) tick();
        run   = 1'b1;
        speed = 4'd3;
        div   = 4'd0;
        tick();
        exp_y = 250 + int'(m_prev & 10'd127);
        chk("wrap_x0", gx(0), 739);
        chk("wrap_pulse", int'(wrap), 1);
        chk("wrap_y0_model", gy(0), exp_y);
        chk("wrap_y0_range", int'(gy(0) >= 250 && gy(0) <= 377), 1);
        chk("wrap_x1", gx(1), 397);
        tick();
        chk("after_wrap_x0", gx(0), 736);
        chk("after_wrap_pulse", int'(wrap), 0);

        Reset = 1'b1;
        #1;
        chk("mid_rst_x0", gx(0), 2);
        chk("mid_rst_x1", gx(1), 400);
        chk("mid_rst_y0", gy(0), 280);
        chk("mid_rst_wrap", int'(wrap), 0);
        Reset = 1'b0;
        run   = 1'b0;
        repeat (3) tick();
        run = 1'b1;
        tick();
        chk("rerun_x0", gx(0), 739);
        chk("rerun_y0", gy(0), 297);
        chk("rerun_pulse", int'(wrap), 1);

        run     = 1'b0;
        start_x = {10'd500, 10'd400, 10'd3};
        pulse_reset();
        run   = 1'b1;
        speed = 4'd3;
        tick();
        chk("exact_x0", gx(0), 0);
        chk("exact_wrap", int'(wrap), 0);
        speed = 4'd0;
        for (int e = 0; e < 4; e++) begin
            tick();
            chk("zero_spd_x0", gx(0), 0);
            chk("zero_spd_wrap", int'(wrap), 0);
        end

        run     = 1'b0;
        speed   = 4'd2;
        start_x = {10'd1, 10'd1, 10'd1};
        pulse_reset();
        run = 1'b1;
        tick();
        chk("all_x0", gx(0), 739);
        chk("all_x1", gx(1), 739);
        chk("all_x2", gx(2), 739);
        chk("all_wrap", int'(wrap), 7);
        chk("all_y0", gy(0), 287);
        chk("all_y1", gy(1), 295);
        chk("all_y2", gy(2), 356);
        tick();
        chk("all_after_wrap", int'(wrap), 0);
        chk("all_after_x0", gx(0), 737);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
